// File: rtl/imem_sync.sv
`default_nettype none
// ============================================================================
// Module   : imem_sync
// Brief    : Synchronous instruction memory with post-reset clear sweep,
//            program-load port and a 1-cycle fetch pipeline with backpressure.
// Revision : 1.0
// ============================================================================
module imem_sync #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          pc,
    input  logic                       fetch_req,
    output logic                       fetch_rdy,
    output logic [DATA_W-1:0]          inst,
    output logic                       inst_valid,
    output logic                       inst_fault,
    input  logic                       inst_ready,
    input  logic                       ld_we,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [DATA_W-1:0]          ld_data,
    output logic                       busy
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   pc_hi;
    logic [IDX_W-1:0]    idx;
    logic                legal;
    logic                accept;

    // Anything at or beyond DEPTH*4 leaves non-zero bits above the index field.
    assign pc_hi     = pc >> (IDX_W + 2);
    assign idx       = pc[IDX_W+1:2];
    assign legal     = (pc[1:0] == 2'b00) && (pc_hi == '0);
    assign busy      = (state == CLEAR);
    assign fetch_rdy = (state == RUN) && (!inst_valid || inst_ready);
    assign accept    = fetch_req && fetch_rdy;

    // Storage carries no reset; the CLEAR sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            inst_fault <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // The read sees the pre-edge word, so a same-cycle load
                    // to the same index returns the old contents.
                    if (accept) begin
                        inst       <= legal ? mem[idx] : '0;
                        inst_fault <= !legal;
                        inst_valid <= 1'b1;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_sync
// Brief    : Directed scoreboard bench for imem_sync (DEPTH=64, DATA_W=32).
// Revision : 1.0
// ============================================================================
module tb_imem_sync;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic              fetch_req;
    logic              fetch_rdy;
    logic [DATA_W-1:0] inst;
    logic              inst_valid;
    logic              inst_fault;
    logic              inst_ready;
    logic              ld_we;
    logic [5:0]        ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              busy;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W:0]   exp_q [$];

    always #5 clk = ~clk;

    imem_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .fetch_req  (fetch_req),
        .fetch_rdy  (fetch_rdy),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_fault (inst_fault),
        .inst_ready (inst_ready),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W:0] expect_fetch(input logic [ADDR_W-1:0] a);
        if (a[1:0] != 2'b00 || a >= ADDR_W'(DEPTH * 4)) return {1'b1, 32'h0};
        return {1'b0, model[a[7:2]]};
    endfunction

    // One clock of the directed sequence: inputs are already applied.
    task automatic step();
        logic [DATA_W:0] front;
        #1;
        if (inst_valid) begin
            chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                front = exp_q[0];
                chk("sb_inst", 64'(inst), 64'(front[DATA_W-1:0]));
                chk("sb_fault", 64'(inst_fault), 64'(front[DATA_W]));
                if (inst_ready) void'(exp_q.pop_front());
            end
        end
        if (fetch_req && fetch_rdy) exp_q.push_back(expect_fetch(pc));
        if (ld_we && !busy) model[ld_addr] = ld_data;
        @(negedge clk);
    endtask

    task automatic run_clear(input string tag);
        int  cnt;
        logic rdy_seen;
        cnt = 0;
        rdy_seen = 1'b0;
        #1;
        while (busy && cnt < 200) begin
            if (fetch_rdy) rdy_seen = 1'b1;
            @(negedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_len"}, 64'(cnt), 64'd64);
        chk({tag, "_rdy_low"}, 64'(rdy_seen), 64'd0);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        reset      = 1'b1;
        pc         = '0;
        fetch_req  = 1'b0;
        inst_ready = 1'b1;
        ld_we      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_fault", 64'(inst_fault), 64'd0);
        chk("rst_rdy", 64'(fetch_rdy), 64'd0);

        // Release with a fetch pending and a load that must be ignored.
        @(negedge clk);
        reset     = 1'b0;
        fetch_req = 1'b1;
        ld_we     = 1'b1;
        ld_addr   = 6'd5;
        ld_data   = 32'h0000_0055;
        run_clear("clear1");
        chk("run_rdy", 64'(fetch_rdy), 64'd1);
        fetch_req = 1'b0;
        ld_we     = 1'b0;

        // Load word 0, then fetch it.
        ld_we = 1'b1; ld_addr = 6'd0; ld_data = 32'h2008_0020;
        step();
        ld_we = 1'b0; fetch_req = 1'b1; pc = 32'h0;
        step();
        fetch_req = 1'b0;
        #1;
        chk("w0_inst", 64'(inst), 64'h2008_0020);
        chk("w0_valid", 64'(inst_valid), 64'd1);
        chk("w0_fault", 64'(inst_fault), 64'd0);
        step();

        // Misaligned, out of range, and the word loaded during clear.
        fetch_req = 1'b1; pc = 32'h102; step();
        pc = 32'h100; step();
        pc = 32'h14;  step();
        fetch_req = 1'b0; step();
        step();

        // Preload distinct words for the stall test.
        ld_we = 1'b1;
        ld_addr = 6'd1; ld_data = 32'h1111_1111; step();
        ld_addr = 6'd2; ld_data = 32'h2222_2222; step();
        ld_addr = 6'd3; ld_data = 32'h3333_3333; step();
        ld_we = 1'b0;

        fetch_req = 1'b1; pc = 32'h0; inst_ready = 1'b1;
        step();
        inst_ready = 1'b0; pc = 32'h4;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rdy", 64'(fetch_rdy), 64'd0);
            chk("stall_inst", 64'(inst), 64'h2008_0020);
            step();
        end
        inst_ready = 1'b1;
        step();
        pc = 32'h8; step();
        fetch_req = 1'b0; step();
        step();
        chk("drain_valid", 64'(inst_valid), 64'd0);
        chk("drain_hold", 64'(inst), 64'h2222_2222);

        // Same-cycle load and fetch of word 3.
        ld_we = 1'b1; ld_addr = 6'd3; ld_data = 32'hDEAD_BEEF;
        fetch_req = 1'b1; pc = 32'hC;
        step();
        #1;
        chk("rbw_old", 64'(inst), 64'h3333_3333);
        ld_we = 1'b0;
        step();
        fetch_req = 1'b0;
        #1;
        chk("rbw_new", 64'(inst), 64'hDEAD_BEEF);
        step();

        // Reset while a result is held.
        inst_ready = 1'b0; fetch_req = 1'b1; pc = 32'hC;
        step();
        fetch_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(inst_valid), 64'd0);
        chk("rst_mid_inst", 64'(inst), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd1);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0; inst_ready = 1'b1;

        // Reset again at clear cycle 30; the sweep restarts from word 0.
        repeat (30) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_clr_busy", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        run_clear("clear2");

        fetch_req = 1'b1; pc = 32'hC; step();
        #1;
        chk("post_clr_w3", 64'(inst), 64'd0);
        pc = 32'h0; step();
        fetch_req = 1'b0; step();
        step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
